// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core: payload latch with
// bubble/flush handling, exception redirect, Tnew countdown and perf counters.

// One data channel of the stage latch: hold, clear-to-bubble or load.
module pipe_stage_ch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] data_q;

    // Channel register; a cleared channel carries zero so bubbles look inert downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      data_q <= '0;
        else if (en_i)   data_q <= clr_i ? '0 : d_i;
    end

    assign q_o = data_q;
endmodule

module pipe_stage_reg #(
    parameter int          DATA_W = 32,
    parameter int          N_CH   = 3,
    parameter int          TNEW_W = 2,
    parameter int          EXC_W  = 5,
    parameter int          CNT_W  = 16,
    parameter logic [31:0] EXC_PC = 32'h0000_4180
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   exc_req,
    input  logic                   in_valid,
    input  logic [31:0]            in_pc,
    input  logic [31:0]            in_ins,
    input  logic                   in_bd,
    input  logic [EXC_W-1:0]       in_exc,
    input  logic [TNEW_W-1:0]      in_tnew,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic                   out_valid,
    output logic [31:0]            out_pc,
    output logic [31:0]            out_ins,
    output logic                   out_bd,
    output logic [EXC_W-1:0]       out_exc,
    output logic [TNEW_W-1:0]      out_tnew,
    output logic [N_CH*DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic              bd_q, bd_d;
    logic [EXC_W-1:0]  exc_q, exc_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    // Exception beats stall, so the channels must still update when exc_req is set.
    logic ch_en, ch_clr;
    assign ch_en  = exc_req | ~stall;
    assign ch_clr = exc_req | flush;

    genvar k;
    generate
        for (k = 0; k < N_CH; k++) begin : g_ch
            pipe_stage_ch #(.DATA_W(DATA_W)) u_ch (
                .clk   (clk),
                .reset (reset),
                .en_i  (ch_en),
                .clr_i (ch_clr),
                .d_i   (in_data[k*DATA_W +: DATA_W]),
                .q_o   (out_data[k*DATA_W +: DATA_W])
            );
        end
    endgenerate

    // Next-state: exception > stall > flush > normal load; default is hold.
    always_comb begin
        valid_d      = valid_q;
        pc_d         = pc_q;
        ins_d        = ins_q;
        bd_d         = bd_q;
        exc_d        = exc_q;
        tnew_d       = tnew_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (exc_req) begin
            valid_d = 1'b0;
            pc_d    = EXC_PC;
            ins_d   = '0;
            bd_d    = 1'b0;
            exc_d   = '0;
            tnew_d  = '0;
        end else if (stall) begin
            if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (flush) begin
            // PC and BD survive the bubble so a later exception reports the right EPC/BD.
            valid_d = 1'b0;
            pc_d    = in_pc;
            ins_d   = '0;
            bd_d    = in_bd;
            exc_d   = '0;
            tnew_d  = '0;
            if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end else begin
            valid_d = in_valid;
            pc_d    = in_pc;
            ins_d   = in_ins;
            bd_d    = in_bd;
            exc_d   = in_exc;
            tnew_d  = (in_valid && in_tnew != '0) ? in_tnew - TNEW_W'(1) : '0;
        end
    end

    // Control/payload state register with async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            pc_q         <= RST_PC;
            ins_q        <= '0;
            bd_q         <= 1'b0;
            exc_q        <= '0;
            tnew_q       <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            pc_q         <= pc_d;
            ins_q        <= ins_d;
            bd_q         <= bd_d;
            exc_q        <= exc_d;
            tnew_q       <= tnew_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_pc     = pc_q;
    assign out_ins    = ins_q;
    assign out_bd     = bd_q;
    assign out_exc    = exc_q;
    assign out_tnew   = tnew_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance plus a narrow
// N_CH=1/DATA_W=8/CNT_W=2 instance sharing the control inputs.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset, stall, flush, exc_req, in_valid, in_bd;
    logic [31:0] in_pc, in_ins;
    logic [4:0]  in_exc;
    logic [1:0]  in_tnew;
    logic [95:0] in_data;
    logic [7:0]  in_data2;

    logic        out_valid, out_bd;
    logic [31:0] out_pc, out_ins;
    logic [4:0]  out_exc;
    logic [1:0]  out_tnew;
    logic [95:0] out_data;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        out_valid2, out_bd2;
    logic [31:0] out_pc2, out_ins2;
    logic [4:0]  out_exc2;
    logic [1:0]  out_tnew2;
    logic [7:0]  out_data2;
    logic [1:0]  stall_cnt2, bubble_cnt2;

    int n_vec = 0;
    int n_err = 0;

    // {valid, pc, ins, bd, exc, tnew} = 73 bits
    logic [72:0] hdr;
    assign hdr = {out_valid, out_pc, out_ins, out_bd, out_exc, out_tnew};

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .exc_req(exc_req),
        .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins), .in_bd(in_bd),
        .in_exc(in_exc), .in_tnew(in_tnew), .in_data(in_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_ins(out_ins), .out_bd(out_bd),
        .out_exc(out_exc), .out_tnew(out_tnew), .out_data(out_data),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .N_CH(1), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .exc_req(exc_req),
        .in_valid(in_valid), .in_pc(in_pc), .in_ins(in_ins), .in_bd(in_bd),
        .in_exc(in_exc), .in_tnew(in_tnew), .in_data(in_data2),
        .out_valid(out_valid2), .out_pc(out_pc2), .out_ins(out_ins2), .out_bd(out_bd2),
        .out_exc(out_exc2), .out_tnew(out_tnew2), .out_data(out_data2),
        .stall_cnt(stall_cnt2), .bubble_cnt(bubble_cnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic bd, input logic [4:0] exc, input logic [1:0] tn,
                         input logic [95:0] d, input logic [7:0] d2);
        @(negedge clk);
        in_valid = v; in_pc = pc; in_ins = ins; in_bd = bd;
        in_exc = exc; in_tnew = tn; in_data = d; in_data2 = d2;
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 0; flush = 0; exc_req = 0;
        in_valid = 0; in_pc = '0; in_ins = '0; in_bd = 0; in_exc = '0; in_tnew = '0;
        in_data = '0; in_data2 = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({hdr, out_data, stall_cnt, bubble_cnt} !== {1'b0, 32'h3000, 32'h0, 1'b0, 5'd0, 2'd0, 96'h0, 16'd0, 16'd0}) begin
            n_err++; $display("FAIL reset_init got hdr=%h data=%h sc=%0d bc=%0d", hdr, out_data, stall_cnt, bubble_cnt);
        end
        reset = 1'b1;
        drive(1, 32'h3100, 32'h1111_2222, 1, 5'd2, 2'd3, {32'h1, 32'h2, 32'h3}, 8'h77);
        tick();
        @(negedge clk); stall = 1;
        tick();
        // mid-cycle async reset with nonzero contents and a nonzero counter
        reset = 1'b0;
        #2;
        n_vec++;
        if ({hdr, out_data, stall_cnt, bubble_cnt, out_data2} !== {1'b0, 32'h3000, 32'h0, 1'b0, 5'd0, 2'd0, 96'h0, 16'd0, 16'd0, 8'h0}) begin
            n_err++; $display("FAIL reset_async got hdr=%h data=%h sc=%0d bc=%0d", hdr, out_data, stall_cnt, bubble_cnt);
        end
        @(negedge clk); reset = 1'b1; stall = 0;
    endtask

    task automatic test_normal_load();
        drive(1, 32'h3004, 32'h3C01_1234, 0, 5'd0, 2'd2,
              {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}, 8'hA5);
        tick();
        n_vec++;
        if (hdr !== {1'b1, 32'h3004, 32'h3C01_1234, 1'b0, 5'd0, 2'd1}) begin
            n_err++; $display("FAIL load1_hdr got %h exp %h", hdr, {1'b1, 32'h3004, 32'h3C01_1234, 1'b0, 5'd0, 2'd1});
        end
        n_vec++;
        if ({out_data, out_data2} !== {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 8'hA5}) begin
            n_err++; $display("FAIL load1_data got %h / %h", out_data, out_data2);
        end
        drive(1, 32'h3008, 32'h0022_1820, 0, 5'd4, 2'd0, {32'h0, 32'hFFFF_FFFF, 32'h5}, 8'h01);
        tick();
        n_vec++;
        if ({hdr, out_data} !== {1'b1, 32'h3008, 32'h0022_1820, 1'b0, 5'd4, 2'd0, 32'h0, 32'hFFFF_FFFF, 32'h5}) begin
            n_err++; $display("FAIL load_tnew0 got hdr=%h data=%h", hdr, out_data);
        end
        drive(1, 32'h300C, 32'h8C22_0000, 1, 5'd0, 2'd3, {32'h7, 32'h8, 32'h9}, 8'h02);
        tick();
        n_vec++;
        if (hdr !== {1'b1, 32'h300C, 32'h8C22_0000, 1'b1, 5'd0, 2'd2}) begin
            n_err++; $display("FAIL load_tnew3 got %h", hdr);
        end
        drive(0, 32'h3010, 32'h0, 1, 5'd0, 2'd2, {32'h11, 32'h22, 32'h33}, 8'h03);
        tick();
        n_vec++;
        if ({hdr, out_data} !== {1'b0, 32'h3010, 32'h0, 1'b1, 5'd0, 2'd0, 32'h11, 32'h22, 32'h33}) begin
            n_err++; $display("FAIL load_invalid got hdr=%h data=%h", hdr, out_data);
        end
    endtask

    task automatic test_stall();
        drive(1, 32'h3020, 32'h8C22_0004, 0, 5'd0, 2'd3, {32'hD0, 32'hD1, 32'hD2}, 8'h44);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1;
            in_pc = 32'h3024 + 32'(i * 4); in_tnew = 2'd1; in_ins = 32'h1234_5678;
            in_data = {32'hE0 + 32'(i), 32'hE1, 32'hE2}; in_data2 = 8'h99;
            tick();
            n_vec++;
            if ({hdr, out_data, out_data2, stall_cnt, stall_cnt2} !==
                {1'b1, 32'h3020, 32'h8C22_0004, 1'b0, 5'd0, 2'd2, 32'hD0, 32'hD1, 32'hD2, 8'h44,
                 16'(i + 1), (i < 3) ? 2'(i + 1) : 2'd3}) begin
                n_err++; $display("FAIL stall_hold%0d got hdr=%h data=%h sc=%0d sc2=%0d", i, hdr, out_data, stall_cnt, stall_cnt2);
            end
        end
        @(negedge clk); stall = 0;
        tick();
        n_vec++;
        if ({hdr, out_data, out_data2, stall_cnt} !==
            {1'b1, 32'h302C, 32'h1234_5678, 1'b0, 5'd0, 2'd0, 32'hE2, 32'hE1, 32'hE2, 8'h99, 16'd3}) begin
            n_err++; $display("FAIL stall_release got hdr=%h data=%h sc=%0d", hdr, out_data, stall_cnt);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h3010, 32'hDEAD_BEEF, 1, 5'd3, 2'd3, {32'h5, 32'h6, 32'h7}, 8'h66);
        flush = 1;
        tick();
        n_vec++;
        if ({hdr, out_data, out_data2, bubble_cnt, stall_cnt} !==
            {1'b0, 32'h3010, 32'h0, 1'b1, 5'd0, 2'd0, 96'h0, 8'h0, 16'd1, 16'd3}) begin
            n_err++; $display("FAIL flush got hdr=%h data=%h bc=%0d sc=%0d", hdr, out_data, bubble_cnt, stall_cnt);
        end
        drive(1, 32'h3014, 32'h1, 0, 5'd0, 2'd1, {32'h1, 32'h2, 32'h3}, 8'h01);
        stall = 1; flush = 1;
        tick();
        n_vec++;
        if ({hdr, out_data, bubble_cnt, stall_cnt} !==
            {1'b0, 32'h3010, 32'h0, 1'b1, 5'd0, 2'd0, 96'h0, 16'd1, 16'd4}) begin
            n_err++; $display("FAIL stall_over_flush got hdr=%h bc=%0d sc=%0d", hdr, bubble_cnt, stall_cnt);
        end
    endtask

    task automatic test_exception();
        drive(1, 32'h3018, 32'hCAFE_F00D, 1, 5'd12, 2'd2, {32'h9, 32'h9, 32'h9}, 8'h09);
        stall = 1; flush = 1; exc_req = 1;
        tick();
        n_vec++;
        if ({hdr, out_data, out_data2, stall_cnt, bubble_cnt} !==
            {1'b0, 32'h4180, 32'h0, 1'b0, 5'd0, 2'd0, 96'h0, 8'h0, 16'd4, 16'd1}) begin
            n_err++; $display("FAIL exception got hdr=%h data=%h sc=%0d bc=%0d", hdr, out_data, stall_cnt, bubble_cnt);
        end
        @(negedge clk); stall = 0; flush = 0; exc_req = 0;
        in_pc = 32'h4180; in_ins = 32'h4000_6800; in_bd = 0; in_exc = 5'd0; in_tnew = 2'd1;
        tick();
        n_vec++;
        if (hdr !== {1'b1, 32'h4180, 32'h4000_6800, 1'b0, 5'd0, 2'd0}) begin
            n_err++; $display("FAIL exc_resume got %h", hdr);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); stall = 1;
            tick();
            n_vec++;
            if ({stall_cnt, stall_cnt2} !== {16'(i + 1), (i < 3) ? 2'(i + 1) : 2'd3}) begin
                n_err++; $display("FAIL stall_sat%0d got %0d/%0d exp %0d/%0d", i, stall_cnt, stall_cnt2, i + 1, (i < 3) ? i + 1 : 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); stall = 0; flush = 1;
            tick();
            n_vec++;
            if ({bubble_cnt, bubble_cnt2, stall_cnt2} !== {16'(i + 1), (i < 3) ? 2'(i + 1) : 2'd3, 2'd3}) begin
                n_err++; $display("FAIL bubble_sat%0d got %0d/%0d", i, bubble_cnt, bubble_cnt2);
            end
        end
        @(negedge clk); flush = 0;
    endtask

    task automatic test_narrow();
        drive(1, 32'h3040, 32'h2402_0007, 0, 5'd0, 2'd1, 96'h0, 8'h5C);
        tick();
        n_vec++;
        if ({out_valid2, out_pc2, out_ins2, out_tnew2, out_data2} !== {1'b1, 32'h3040, 32'h2402_0007, 2'd0, 8'h5C}) begin
            n_err++; $display("FAIL narrow_load got v=%b pc=%h ins=%h tn=%0d d=%h", out_valid2, out_pc2, out_ins2, out_tnew2, out_data2);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_stall();
        test_flush();
        test_exception();
        test_saturation();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
